// File: rtl/bus_arb_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: state encoding, bus
// select values and parameter defaults.
package bus_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned CNT_W_DEFAULT   = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_WAIT_CPU = 2'd1;
    localparam arb_state_t ST_GRANT    = 2'd2;
    localparam arb_state_t ST_RELEASE  = 2'd3;

    localparam logic BUS_CPU = 1'b0;
    localparam logic BUS_DMA = 1'b1;

endpackage

// File: rtl/grant_counter.sv
// Saturating grant-cycle counter with clear, increment enable and a
// terminal-count flag at TIMEOUT-1.
module grant_counter #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    // Count grant cycles; hold at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA shared memory bus arbiter. Grants the bus to the DMA only when
// no CPU access is in flight, stalls the CPU during the grant and pulses a
// completion interrupt on hand-back.
// Optional: define GRANT_TIMEOUT_EN to force a release after TIMEOUT grant
// cycles and raise a sticky grant_err.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BR,
    input  logic dma_done,
    input  logic cpu_mem_req,
    input  logic cpu_mem_busy,
    output logic BG,
    output logic bus_sel,
    output logic cpu_stall,
    output logic cpu_irq,
    output logic grant_err
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             irq_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tc_c;

`ifdef GRANT_TIMEOUT_EN
    logic blocked;
    logic blocked_nxt;
    logic err_nxt;
`endif

    grant_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_grant_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (state != ST_GRANT),
        .inc   (state == ST_GRANT),
        .cnt   (cnt),
        .tc_c  (tc_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        irq_nxt   = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        blocked_nxt = blocked;
        err_nxt     = grant_err;
`endif
        case (state)
            ST_IDLE: begin
`ifdef GRANT_TIMEOUT_EN
                // After a forced release BR must be seen low before re-granting.
                if (!BR) begin
                    blocked_nxt = 1'b0;
                end else if (!blocked) begin
                    state_nxt = cpu_mem_busy ? ST_WAIT_CPU : ST_GRANT;
                end
`else
                if (BR) begin
                    state_nxt = cpu_mem_busy ? ST_WAIT_CPU : ST_GRANT;
                end
`endif
            end
            ST_WAIT_CPU: begin
                if (!BR) begin
                    state_nxt = ST_IDLE;
                end else if (!cpu_mem_busy) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Completion wins over withdrawal when both occur together.
                if (dma_done) begin
                    state_nxt = ST_RELEASE;
                    irq_nxt   = 1'b1;
                end else if (!BR) begin
                    state_nxt = ST_RELEASE;
`ifdef GRANT_TIMEOUT_EN
                end else if (tc_c) begin
                    state_nxt   = ST_RELEASE;
                    err_nxt     = 1'b1;
                    blocked_nxt = 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                // BR is ignored here: the DMA is still reacting to BG falling.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; bus_sel moves only on clock edges.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            BG      <= 1'b0;
            bus_sel <= BUS_CPU;
            cpu_irq <= 1'b0;
        end else begin
            state   <= state_nxt;
            BG      <= (state_nxt == ST_GRANT);
            bus_sel <= (state_nxt == ST_GRANT) ? BUS_DMA : BUS_CPU;
            cpu_irq <= irq_nxt;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    // Sticky timeout error and re-grant block.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_err <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            grant_err <= err_nxt;
            blocked   <= blocked_nxt;
        end
    end
`else
    assign grant_err = 1'b0;
`endif

    assign cpu_stall = cpu_mem_req && ((state == ST_GRANT) || (state == ST_RELEASE));

    // Sanity invariants: counter is idle outside a grant, terminal count only near one.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if ((state == ST_IDLE) || (state == ST_WAIT_CPU)) begin
                assert (cnt == '0);
            end
            if (tc_c && (TIMEOUT > 1)) begin
                assert ((state == ST_GRANT) || (state == ST_RELEASE));
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter. Each vector drives one cycle of
// inputs and queues the outputs expected during that cycle; a monitor pops
// and compares on the falling edge.
module tb_bus_arbiter;

    localparam int unsigned TB_TIMEOUT = 8;

    logic CLK = 1'b0;
    logic RESET;
    logic BR;
    logic dma_done;
    logic cpu_mem_req;
    logic cpu_mem_busy;
    logic BG;
    logic bus_sel;
    logic cpu_stall;
    logic cpu_irq;
    logic grant_err;

    typedef struct {
        bit    bg;
        bit    irq;
        bit    err;
        bit    stall;
        string name;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 CLK = ~CLK;

    bus_arbiter #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BR           (BR),
        .dma_done     (dma_done),
        .cpu_mem_req  (cpu_mem_req),
        .cpu_mem_busy (cpu_mem_busy),
        .BG           (BG),
        .bus_sel      (bus_sel),
        .cpu_stall    (cpu_stall),
        .cpu_irq      (cpu_irq),
        .grant_err    (grant_err)
    );

    task automatic chk(input string nm, input string sig, input logic act, input bit exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %b expected %b at %0t", nm, sig, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, queue the outputs expected during this cycle.
    task automatic step(input bit rst, input bit br, input bit done, input bit req,
                        input bit busy, input bit e_bg, input bit e_irq,
                        input bit e_err, input bit e_stall, input string nm);
        exp_t e;
        RESET        = rst;
        BR           = br;
        dma_done     = done;
        cpu_mem_req  = req;
        cpu_mem_busy = busy;
        e.bg    = e_bg;
        e.irq   = e_irq;
        e.err   = e_err;
        e.stall = e_stall;
        e.name  = nm;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "BG",        BG,        e.bg);
                chk(e.name, "bus_sel",   bus_sel,   e.bg);
                chk(e.name, "cpu_irq",   cpu_irq,   e.irq);
                chk(e.name, "grant_err", grant_err, e.err);
                chk(e.name, "cpu_stall", cpu_stall, e.stall);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; BR = 1'b0; dma_done = 1'b0; cpu_mem_req = 1'b0; cpu_mem_busy = 1'b0;
        @(posedge CLK);
        #1;

        // Basic grant, stall, completion irq
        step(1,0,0,0,0, 0,0,0,0, "reset");
        step(0,1,0,0,0, 0,0,0,0, "t1_req");
        step(0,1,0,1,0, 1,0,0,1, "t1_grant_stall");
        for (int i = 0; i < 10; i++) step(0,1,0,0,0, 1,0,0,0, "t1_grant");
        step(0,1,1,1,0, 1,0,0,1, "t1_done");
        step(0,1,0,1,0, 0,1,0,1, "t1_release_irq");
        step(0,0,0,1,0, 0,0,0,0, "t1_idle_nostall");

        // Wait for CPU access to finish
        step(0,1,0,0,1, 0,0,0,0, "t2_busy0");
        step(0,1,0,1,1, 0,0,0,0, "t2_wait1");
        step(0,1,0,0,1, 0,0,0,0, "t2_wait2");
        step(0,1,0,0,0, 0,0,0,0, "t2_busy_drop");
        step(0,1,0,0,0, 1,0,0,0, "t2_grant");

        // Withdrawal in GRANT and in WAIT_CPU
        step(0,0,0,0,0, 1,0,0,0, "t3_withdraw");
        step(0,0,0,1,0, 0,0,0,1, "t3_release_noirq");
        step(0,0,0,0,0, 0,0,0,0, "t3_idle");
        step(0,1,0,0,1, 0,0,0,0, "t3_wait_enter");
        step(0,0,0,0,1, 0,0,0,0, "t3_wait_drop");
        step(0,0,0,0,0, 0,0,0,0, "t3_idle2");
        step(0,0,0,0,0, 0,0,0,0, "t3_idle3");

        // Done with BR low, reset mid-grant
        step(0,1,0,0,0, 0,0,0,0, "t4_req");
        step(0,0,1,0,0, 1,0,0,0, "t4_done_brlow");
        step(0,0,0,0,0, 0,1,0,0, "t4_irq");
        step(0,0,0,0,0, 0,0,0,0, "t4_irq_once");
        step(0,1,0,0,0, 0,0,0,0, "t4_req2");
        step(1,1,0,1,0, 1,0,0,1, "t4_rst_in_grant");
        step(0,0,0,1,0, 0,0,0,0, "t4_after_rst");
        step(0,1,0,0,0, 0,0,0,0, "t4_req3");
        step(1,1,1,0,0, 1,0,0,0, "t4_rst_with_done");
        step(0,0,0,0,0, 0,0,0,0, "t4_no_irq_after_rst");

        // Back-to-back grants: exactly two BG=0 cycles between them
        step(0,1,0,0,0, 0,0,0,0, "t6_req");
        step(0,1,1,1,0, 1,0,0,1, "t6_done");
        step(0,1,0,1,0, 0,1,0,1, "t6_release");
        step(0,1,0,1,0, 0,0,0,0, "t6_gap_idle");
        step(0,1,0,1,0, 1,0,0,1, "t6_regrant");
        step(0,1,1,0,0, 1,0,0,0, "t6_done2");
        step(0,0,0,0,0, 0,1,0,0, "t6_release2");
        step(0,0,0,0,0, 0,0,0,0, "t6_idle");

`ifdef GRANT_TIMEOUT_EN
        // Forced release after TB_TIMEOUT grant cycles
        step(0,1,0,0,0, 0,0,0,0, "t5_req");
        for (int i = 0; i < int'(TB_TIMEOUT); i++) step(0,1,0,0,0, 1,0,0,0, "t5_grant");
        step(0,1,0,0,0, 0,0,1,0, "t5_forced_release");
        step(0,1,0,0,0, 0,0,1,0, "t5_blocked1");
        step(0,1,0,0,0, 0,0,1,0, "t5_blocked2");
        step(0,0,0,0,0, 0,0,1,0, "t5_br_low");
        step(0,1,0,0,0, 0,0,1,0, "t5_req_again");
        step(0,1,0,0,0, 1,0,1,0, "t5_regrant");
        step(0,1,1,0,0, 1,0,1,0, "t5_done");
        step(0,0,0,0,0, 0,1,1,0, "t5_release_irq");
        step(0,0,0,0,0, 0,0,1,0, "t5_err_sticky");
`else
        // No timeout: grant held well past counter saturation
        step(0,1,0,0,0, 0,0,0,0, "t5_req");
        for (int i = 0; i < 300; i++) step(0,1,0,0,0, 1,0,0,0, "t5_held");
        step(0,1,1,0,0, 1,0,0,0, "t5_done");
        step(0,0,0,0,0, 0,1,0,0, "t5_release_irq");
        step(0,0,0,0,0, 0,0,0,0, "t5_idle");
`endif

        // Drain: every queued expectation must have been consumed
        repeat (3) @(negedge CLK);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Owns the shared memory bus between the CPU and the DMA engine. It turns the DMA bus request (BR) into a registered bus grant (BG), and only grants once the CPU has no memory access in flight. While the DMA owns the bus it stalls the CPU, and when the DMA finishes it hands the bus back and raises a one-cycle completion interrupt to the CPU. It sits at the top level between the CPU, the DMA and the memory address/data mux.

Parameters:
TIMEOUT, 64, maximum number of consecutive grant cycles before a forced release (used only with GRANT_TIMEOUT_EN).
CNT_W, 8, width of the grant-cycle counter; must hold TIMEOUT.

Ports:
CLK  in  1  system clock; all state updates on its rising edge.
RESET  in  1  synchronous, active-high reset.
BR  in  1  bus request from the DMA; level, held until the DMA sees BG fall.
dma_done  in  1  DMA end-of-transfer indication; level, may lead the final transfer by one cycle.
cpu_mem_req  in  1  CPU wants the memory bus this cycle.
cpu_mem_busy  in  1  CPU memory access in flight; the bus must not be taken while high.
BG  out  1  bus grant to the DMA; registered.
bus_sel  out  1  memory mux select; 0 = CPU, 1 = DMA; registered, equals BG.
cpu_stall  out  1  combinational; = cpu_mem_req & (state is GRANT or RELEASE).
cpu_irq  out  1  one-cycle pulse to the CPU: the DMA transfer completed.
grant_err  out  1  sticky forced-release flag; constant 0 without GRANT_TIMEOUT_EN.

Behaviour:
- Reset (RESET=1 at a rising edge of CLK):
  - state=IDLE; BG=0, bus_sel=0, cpu_irq=0, grant_err=0; counter=0.
  - This applies in every state. A reset during GRANT drops BG at that same edge.
- States: IDLE, WAIT_CPU, GRANT, RELEASE. BG/bus_sel are 1 only in GRANT.
- IDLE:
  - BR & !cpu_mem_busy -> GRANT; BG rises at that edge, so there is 1 cycle from BR sampled to BG high.
  - BR & cpu_mem_busy -> WAIT_CPU.
  - Otherwise stay in IDLE.
- WAIT_CPU:
  - Hold BG=0 until cpu_mem_busy=0, then -> GRANT.
  - BR dropping while waiting -> IDLE, with no grant and no irq.
- GRANT:
  - The counter increments each cycle, saturating at 2^CNT_W-1.
  - dma_done=1 -> RELEASE, and a completion is latched.
  - BR=0 without dma_done (DMA withdrew) -> RELEASE, with no completion.
  - dma_done and BR=0 in the same cycle is treated as completion.
- RELEASE (exactly 1 cycle):
  - BG=0 and bus_sel=0, registered at entry.
  - cpu_irq=1 for this single cycle if the completion was latched.
  - BR is ignored here, because the DMA drops BR in response to BG falling.
  - -> IDLE; counter cleared.
- Back-to-back requests: a BR still high in IDLE after RELEASE is a new request. The minimum gap between grants is therefore 2 cycles of BG=0.
- cpu_stall: the CPU must not issue memory accesses while stalled. bus_sel switches only on clock edges, never mid-cycle.
- cpu_mem_busy is ignored in GRANT; it is the CPU's responsibility not to start an access while stalled.

Optional Feature:
GRANT_TIMEOUT_EN
- Defined:
  - In GRANT, when counter reaches TIMEOUT-1 with no dma_done -> forced RELEASE.
  - grant_err is set and stays set until RESET.
  - No cpu_irq on a forced release.
  - The DMA is not re-granted until BR is seen low for at least one cycle in IDLE.
- Not defined: no timeout; grant_err is tied to 0; the counter is status only.

Decomposition:
- Shared package bus_arb_pkg holds:
  - the state encoding (2-bit typedef: IDLE=0, WAIT_CPU=1, GRANT=2, RELEASE=3);
  - the BUS_CPU=0 / BUS_DMA=1 select constants;
  - the default TIMEOUT.
- Sub-module grant_counter (saturating counter with clear, increment enable and a terminal-count output) is natural. It keeps the FSM purely next-state/output logic.

Test Plan:
1. Reset, then BR=1 with cpu_mem_busy=0 at cycle 2 -> BG=1 from cycle 3 with bus_sel=1; cpu_mem_req=1 gives cpu_stall=1; dma_done=1 at cycle 15 -> BG=0 at cycle 16, cpu_irq=1 for exactly cycle 16, IDLE at cycle 17.
2. BR=1 while cpu_mem_busy=1 for 3 cycles -> WAIT_CPU, BG stays 0; BG rises on the edge after cpu_mem_busy falls; no overlap of bus_sel=1 with busy=1.
3. BR drops mid-GRANT without dma_done -> one RELEASE cycle, cpu_irq stays 0; BR drop in WAIT_CPU -> back to IDLE, BG never rises.
4. dma_done and BR=0 in the same GRANT cycle -> cpu_irq pulses once; RESET=1 mid-GRANT -> BG=0, bus_sel=0, cpu_irq=0 on that edge.
5. With GRANT_TIMEOUT_EN and TIMEOUT=8, hold BR=1, never assert dma_done -> BG high for exactly 8 cycles, grant_err=1 sticky, no irq, no re-grant until BR low one cycle; without the macro -> BG held indefinitely, grant_err=0.
6. Back-to-back: second BR asserted right after RELEASE -> exactly 2 cycles of BG=0 between grants; cpu_stall only in GRANT and RELEASE cycles.
